// File: rtl/reg_file_sb.sv
// reg_file_sb: 32-entry integer register file with bypassed read ports and a per-register pending-write scoreboard
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall
);
  logic [XLEN-1:0]   regs [NREG];
  logic [PEND_W-1:0] pend [NREG];
  logic [PEND_W-1:0] pend_nxt [NREG];
  logic              issue_acc;
  always_comb begin
    rs1_data    = rs1_addr == '0 ? '0 : (wr_en && wr_addr == rs1_addr) ? wr_data : regs[rs1_addr];
    rs2_data    = rs2_addr == '0 ? '0 : (wr_en && wr_addr == rs2_addr) ? wr_data : regs[rs2_addr];
    rs1_busy    = rs1_addr != '0 && pend[rs1_addr] != '0 && !(wr_en && wr_addr == rs1_addr);
    rs2_busy    = rs2_addr != '0 && pend[rs2_addr] != '0 && !(wr_en && wr_addr == rs2_addr);
    // a saturated counter only has room if the same register retires this cycle
    issue_ready = !flush && !(issue_rd != '0 && &pend[issue_rd] && !(wr_en && wr_addr == issue_rd));
    issue_acc   = issue_valid && issue_ready;
    stall       = rs1_busy || rs2_busy || (issue_valid && !issue_ready);
  end
  for (genvar g = 0; g < NREG; g++) begin : g_pend
    localparam logic [AW-1:0] ra = AW'(g);
    logic inc, dec;
    assign inc = issue_acc && issue_rd == ra;
    assign dec = wr_en && wr_addr == ra && pend[g] != '0;
    assign pend_nxt[g] = (flush || g == 0) ? '0 :
                         (inc && !dec)     ? pend[g] + 1'b1 :
                         (dec && !inc)     ? pend[g] - 1'b1 : pend[g];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
      for (int i = 0; i < NREG; i++) pend[i] <= pend_nxt[i];
    end
endmodule
